// File: rtl/spi_input_conditioner.sv
// Synchronizes and glitch-filters the raw SPI pins (sclk, cs, mosi) and emits registered edge pulses.
// Define CS_GATE_EN to suppress sclk edge pulses while chip-select is deasserted.

module spi_input_conditioner #(
    parameter int unsigned WAITTIME = 3,
    parameter int unsigned CNT_W    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_in,
    input  logic cs_in,
    input  logic mosi_in,
    output logic sclk_cond,
    output logic sclk_pos,
    output logic sclk_neg,
    output logic cs_cond,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_cond
);

    // Channel bit order is {mosi, cs, sclk}; cs idles high (deselected).
    localparam logic [2:0]       RST_VAL = 3'b010;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAITTIME);

    logic [2:0]            raw;
    logic [2:0]            sync0_q;
    logic [2:0]            sync1_q;
    logic [2:0]            cond_q;
    logic [2:0]            cond_d;
    logic [2:0]            chg;
    logic [2:0][CNT_W-1:0] cnt_q;
    logic [2:0][CNT_W-1:0] cnt_d;
    // {cs_rise, cs_fall, sclk_neg, sclk_pos}
    logic [3:0]            pulse_q;
    logic [3:0]            pulse_d;
    logic                  sclk_gate;

    assign raw = {mosi_in, cs_in, sclk_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= RST_VAL;
            sync1_q <= RST_VAL;
            cond_q  <= RST_VAL;
            cnt_q   <= '0;
            pulse_q <= '0;
        end else begin
            sync0_q <= raw;
            sync1_q <= sync0_q;
            cond_q  <= cond_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // A level is accepted only after WAITTIME+1 consecutive disagreeing samples;
    // any agreeing sample restarts the window.
    always_comb begin
        cond_d = cond_q;
        cnt_d  = '0;
        chg    = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync1_q[i] != cond_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    cond_d[i] = sync1_q[i];
                    chg[i]    = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

`ifdef CS_GATE_EN
    assign sclk_gate = cond_q[1];
`else
    assign sclk_gate = 1'b0;
`endif

    always_comb begin
        pulse_d    = '0;
        pulse_d[0] = chg[0] &  sync1_q[0] & ~sclk_gate;
        pulse_d[1] = chg[0] & ~sync1_q[0] & ~sclk_gate;
        pulse_d[2] = chg[1] & ~sync1_q[1];
        pulse_d[3] = chg[1] &  sync1_q[1];
    end

    assign sclk_cond = cond_q[0];
    assign cs_cond   = cond_q[1];
    assign mosi_cond = cond_q[2];
    assign sclk_pos  = pulse_q[0];
    assign sclk_neg  = pulse_q[1];
    assign cs_fall   = pulse_q[2];
    assign cs_rise   = pulse_q[3];

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Directed bench for spi_input_conditioner: latency, glitch rejection, frame ordering, reset.

module tb_spi_input_conditioner;

    logic clk;
    logic rst_n;
    logic sclk_in;
    logic cs_in;
    logic mosi_in;
    logic sclk_cond;
    logic sclk_pos;
    logic sclk_neg;
    logic cs_cond;
    logic cs_fall;
    logic cs_rise;
    logic mosi_cond;

    int total;
    int bad;

    spi_input_conditioner #(
        .WAITTIME(3),
        .CNT_W   (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk_in  (sclk_in),
        .cs_in    (cs_in),
        .mosi_in  (mosi_in),
        .sclk_cond(sclk_cond),
        .sclk_pos (sclk_pos),
        .sclk_neg (sclk_neg),
        .cs_cond  (cs_cond),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .mosi_cond(mosi_cond)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor, sampled on the falling edge.
    int   cyc;
    int   n_pos, n_neg, n_fall, n_rise, n_mrise, consec;
    int   first_pos, last_neg, fall_cyc, rise_cyc;
    logic [3:0] prev_pv;
    logic       prev_mosi;

    initial begin
        cyc = 0; n_pos = 0; n_neg = 0; n_fall = 0; n_rise = 0; n_mrise = 0; consec = 0;
        first_pos = -1; last_neg = -1; fall_cyc = -1; rise_cyc = -1;
        prev_pv = '0; prev_mosi = 1'b0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sclk_pos) begin
            n_pos++;
            if (first_pos < 0) first_pos = cyc;
        end
        if (sclk_neg) begin
            n_neg++;
            last_neg = cyc;
        end
        if (cs_fall) begin
            n_fall++;
            fall_cyc = cyc;
        end
        if (cs_rise) begin
            n_rise++;
            rise_cyc = cyc;
        end
        if (mosi_cond && !prev_mosi) n_mrise++;
        if (({cs_rise, cs_fall, sclk_neg, sclk_pos} & prev_pv) != 4'b0) consec++;
        prev_pv   = {cs_rise, cs_fall, sclk_neg, sclk_pos};
        prev_mosi = mosi_cond;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int s_pos, s_neg, s_fall, s_rise;

    task automatic snap();
        s_pos  = n_pos;
        s_neg  = n_neg;
        s_fall = n_fall;
        s_rise = n_rise;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n   = 1'b0;
        sclk_in = 1'b1;
        cs_in   = 1'b0;
        mosi_in = 1'b0;

        // Reset with non-idle pins: outputs hold reset values.
        steps(3);
        check("rst_sclk_cond", 32'(sclk_cond), 0);
        check("rst_cs_cond", 32'(cs_cond), 1);
        check("rst_mosi_cond", 32'(mosi_cond), 0);
        check("rst_pulses", 32'({sclk_pos, sclk_neg, cs_fall, cs_rise}), 0);

        rst_n = 1'b1;
        steps(5);
        check("rel_e5_pulses", 32'({sclk_pos, cs_fall}), 0);
        check("rel_e5_conds", 32'({sclk_cond, cs_cond}), 32'b01);
        steps(1);
`ifdef CS_GATE_EN
        check("rel_e6_sclk_pos", 32'(sclk_pos), 0);
`else
        check("rel_e6_sclk_pos", 32'(sclk_pos), 1);
`endif
        check("rel_e6_cs_fall", 32'(cs_fall), 1);
        check("rel_e6_conds", 32'({sclk_cond, cs_cond}), 32'b10);
        steps(1);
        check("rel_e7_pulses", 32'({sclk_pos, cs_fall}), 0);

        // sclk back low, then a clean 0->1.
        sclk_in = 1'b0;
        steps(5);
        check("neg_e5", 32'({sclk_neg, sclk_cond}), 32'b01);
        steps(1);
        check("neg_e6", 32'({sclk_neg, sclk_cond}), 32'b10);
        steps(4);
        snap();
        sclk_in = 1'b1;
        steps(5);
        check("pos_e5", 32'({sclk_pos, sclk_cond}), 32'b00);
        steps(1);
        check("pos_e6", 32'({sclk_pos, sclk_neg, sclk_cond}), 32'b101);
        steps(1);
        check("pos_e7", 32'(sclk_pos), 0);
        steps(3);
        check("pos_count", 32'(n_pos - s_pos), 1);
        check("pos_neg_count", 32'(n_neg - s_neg), 0);
        sclk_in = 1'b0;
        steps(10);
        check("pos_back_low", 32'(sclk_cond), 0);

        // Glitch of WAITTIME cycles rejected, WAITTIME+1 accepted.
        snap();
        sclk_in = 1'b1;
        steps(3);
        sclk_in = 1'b0;
        steps(10);
        check("glitch3_pos", 32'(n_pos - s_pos), 0);
        check("glitch3_cond", 32'(sclk_cond), 0);
        snap();
        sclk_in = 1'b1;
        steps(4);
        sclk_in = 1'b0;
        steps(10);
        check("glitch4_pos", 32'(n_pos - s_pos), 1);
        check("glitch4_neg", 32'(n_neg - s_neg), 1);

        // Bouncing mosi settles high; rises once, 6 edges after the last change.
        for (int k = 0; k < 4; k++) begin
            mosi_in = ~mosi_in;
            steps(2);
        end
        check("mosi_bounce_cond", 32'(mosi_cond), 0);
        mosi_in = 1'b1;
        steps(5);
        check("mosi_e5", 32'(mosi_cond), 0);
        steps(1);
        check("mosi_e6", 32'(mosi_cond), 1);
        steps(4);
        check("mosi_rises", 32'(n_mrise), 1);

        // Full frame.
        cs_in = 1'b1;
        steps(10);
        check("cs_deselect", 32'(cs_cond), 1);
        snap();
        first_pos = -1;
        cs_in = 1'b0;
        steps(10);
        for (int k = 0; k < 8; k++) begin
            sclk_in = 1'b1;
            steps(8);
            sclk_in = 1'b0;
            steps(8);
        end
        steps(10);
        cs_in = 1'b1;
        steps(10);
        check("frame_fall", 32'(n_fall - s_fall), 1);
        check("frame_pos", 32'(n_pos - s_pos), 8);
        check("frame_neg", 32'(n_neg - s_neg), 8);
        check("frame_rise", 32'(n_rise - s_rise), 1);
        check("frame_order_start", 32'(fall_cyc < first_pos), 1);
        check("frame_order_end", 32'(last_neg < rise_cyc), 1);

        // sclk activity outside a frame.
        snap();
        for (int k = 0; k < 2; k++) begin
            sclk_in = 1'b1;
            steps(8);
            check("idle_sclk_cond_hi", 32'(sclk_cond), 1);
            sclk_in = 1'b0;
            steps(8);
        end
`ifdef CS_GATE_EN
        check("idle_pos", 32'(n_pos - s_pos), 0);
        check("idle_neg", 32'(n_neg - s_neg), 0);
`else
        check("idle_pos", 32'(n_pos - s_pos), 2);
        check("idle_neg", 32'(n_neg - s_neg), 2);
`endif

        // Reset while the sclk counter sits at 2.
        cs_in = 1'b0;
        steps(10);
        snap();
        sclk_in = 1'b1;
        steps(4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_conds", 32'({sclk_cond, cs_cond, mosi_cond}), 32'b010);
        check("mid_rst_pulses", 32'({sclk_pos, sclk_neg, cs_fall, cs_rise}), 0);
        sclk_in = 1'b0;
        cs_in   = 1'b1;
        mosi_in = 1'b0;
        steps(3);
        rst_n = 1'b1;
        steps(12);
        check("mid_rst_after_pos", 32'(n_pos - s_pos), 0);
        check("mid_rst_after_cs", 32'((n_fall - s_fall) + (n_rise - s_rise)), 0);
        check("mid_rst_after_conds", 32'({sclk_cond, cs_cond, mosi_cond}), 32'b010);

        check("no_consecutive_pulses", 32'(consec), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
